// File: rtl/wb_arbiter.sv
// Writeback arbiter: three per-unit result FIFOs drained round-robin into one
// registered register-file write port.

// Per-unit result FIFO. Storage is not reset; only pointers and count are.
module wb_unit_fifo #(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int W     = 37
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_req,
  input  logic [W-1:0] push_entry,
  input  logic         pop,
  output logic         ready,
  output logic         empty,
  output logic [W-1:0] head,
  output logic         overflow
);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop_ok;

  // ready looks only at the registered count: a same-cycle pop never bypasses
  assign ready    = (count != FULL);
  assign empty    = (count == '0);
  assign push     = push_req & ready;
  assign pop_ok   = pop & ~empty;
  assign overflow = push_req & ~ready;
  assign head     = mem[rd_ptr];

  // pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^PW)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // result storage
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end
endmodule

module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_wb_writereg,
  input  logic [4:0]  x_wb_regdest,
  input  logic [31:0] x_wb_wbvalue,
  output logic        x_wb_ready,
  input  logic        y_wb_writereg,
  input  logic [4:0]  y_wb_regdest,
  input  logic [31:0] y_wb_wbvalue,
  output logic        y_wb_ready,
  input  logic        m_wb_writereg,
  input  logic [4:0]  m_wb_regdest,
  input  logic [31:0] m_wb_wbvalue,
  output logic        m_wb_ready,
  output logic        wb_reg_en,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_reg_data,
  output logic [1:0]  wb_grant,
  output logic        wb_overflow
);
  localparam int NUM_UNITS = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_res_t;

  localparam int W = $bits(wb_res_t);

  // unit index 0=X, 1=Y, 2=M; grant code on the port is index+1
  logic [NUM_UNITS-1:0]        writereg;
  logic [NUM_UNITS-1:0][4:0]   regdest;
  logic [NUM_UNITS-1:0][31:0]  wbvalue;
  logic [NUM_UNITS-1:0]        push_req, pop, ready, empty, ovf_evt;
  logic [NUM_UNITS-1:0][W-1:0] head;

  logic [1:0] last_idx;
  logic [1:0] grant_idx, cand;
  logic       grant_vld;
  wb_res_t    grant_res;

  assign writereg = {m_wb_writereg, y_wb_writereg, x_wb_writereg};
  assign regdest  = {m_wb_regdest,  y_wb_regdest,  x_wb_regdest};
  assign wbvalue  = {m_wb_wbvalue,  y_wb_wbvalue,  x_wb_wbvalue};

  assign x_wb_ready = ready[0];
  assign y_wb_ready = ready[1];
  assign m_wb_ready = ready[2];

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    // writes to r0 are dropped before they reach the FIFO
    assign push_req[i] = writereg[i] & (regdest[i] != 5'd0);
    assign pop[i]      = grant_vld & (grant_idx == 2'(i));

    wb_unit_fifo #(.DEPTH(DEPTH), .PW(PW), .W(W)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_req   (push_req[i]),
      .push_entry ({regdest[i], wbvalue[i]}),
      .pop        (pop[i]),
      .ready      (ready[i]),
      .empty      (empty[i]),
      .head       (head[i]),
      .overflow   (ovf_evt[i])
    );
  end

  // round-robin pick: first non-empty unit after the last granted one
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      cand = 2'((int'(last_idx) + k) % NUM_UNITS);
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_res = wb_res_t'(head[grant_idx]);

  // registered writeback port, rotation pointer and sticky overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_reg_en   <= 1'b0;
      wb_reg_addr <= '0;
      wb_reg_data <= '0;
      wb_grant    <= 2'd0;
      wb_overflow <= 1'b0;
      last_idx    <= 2'd2;
    end else begin
      wb_reg_en <= grant_vld;
      if (grant_vld) begin
        wb_reg_addr <= grant_res.addr;
        wb_reg_data <= grant_res.data;
        wb_grant    <= grant_idx + 2'd1;
        last_idx    <= grant_idx;
      end else begin
        wb_grant <= 2'd0;
      end
      if (|ovf_evt) wb_overflow <= 1'b1;
    end
  end
endmodule
